// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Brief    : RV32I opcodes, immediate-format encoding and the canonical NOP.
// Revision : 1.0
// ============================================================================
package rv32i_pkg;

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_csr    = 7'b1110011;

    localparam logic [31:0] NOP_IR = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_B,
        IMM_S,
        IMM_U,
        IMM_J,
        IMM_SHAMT,
        IMM_CSR,
        IMM_NONE
    } imm_type_e;

endpackage
`default_nettype wire

// File: rtl/id_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_pipe_stage_if
// Brief    : IF->ID input handshake, register-file taps and ID/EX outputs.
// Revision : 1.0
// ============================================================================
interface id_pipe_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [31:0]     in_ir;
    logic [XLEN-1:0] in_pc;
    logic            in_ready;
    logic            flush;
    logic            ex_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            hazard;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [11:0]     out_csr_addr;
    logic [XLEN-1:0] out_imm;
    logic            out_wr_reg_n;
    logic            out_wr_csr_n;
    logic            out_is_load;
    logic            out_illegal;

    modport master (
        output in_valid, in_ir, in_pc, flush, ex_ready,
        input  in_ready, rs1, rs2, hazard,
        input  out_valid, out_pc, out_rd, out_rs1, out_rs2, out_opcode,
        input  out_funct3, out_funct7, out_csr_addr, out_imm,
        input  out_wr_reg_n, out_wr_csr_n, out_is_load, out_illegal
    );

    modport slave (
        input  in_valid, in_ir, in_pc, flush, ex_ready,
        output in_ready, rs1, rs2, hazard,
        output out_valid, out_pc, out_rd, out_rs1, out_rs2, out_opcode,
        output out_funct3, out_funct7, out_csr_addr, out_imm,
        output out_wr_reg_n, out_wr_csr_n, out_is_load, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Brief    : Combinational immediate extractor, extended to XLEN.
// Revision : 1.0
// ============================================================================
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);
    logic [31:0] w_imm32;
    logic        w_unused;

    // The opcode field carries no immediate bits; the format is already in imm_type.
    assign w_unused = ^ir[6:0];

    always_comb begin
        w_imm32 = '0;
        case (imm_type)
            IMM_I:     w_imm32 = {{20{ir[31]}}, ir[31:20]};
            IMM_S:     w_imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:     w_imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:     w_imm32 = {ir[31:12], 12'b0};
            IMM_J:     w_imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            IMM_SHAMT: w_imm32 = {27'b0, ir[24:20]};
            IMM_CSR:   w_imm32 = {27'b0, ir[19:15]};
            default:   w_imm32 = '0;
        endcase
    end

    // Zero-extended formats have bit 31 clear, so a uniform sign extension is safe.
    if (XLEN > 32) begin : g_sext
        assign imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_native
        assign imm = w_imm32;
    end

endmodule
`default_nettype wire

// File: rtl/id_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_pipe_stage
// Brief    : RV32I decode stage with ID/EX register, load-use hazard and flush.
// Revision : 1.0
// ============================================================================
module id_pipe_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit CSR_EN         = 1'b1,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    id_pipe_stage_if.slave bus
);
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic            w_legal;
    logic            w_wr_reg;
    logic            w_wr_csr;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    imm_type_e       w_imm_type;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_in_ready;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [11:0]     r_csr_addr;
    logic [XLEN-1:0] r_imm;
    logic            r_wr_reg_n;
    logic            r_wr_csr_n;
    logic            r_is_load;
    logic            r_illegal;

    assign w_opcode = bus.in_ir[6:0];
    assign w_funct3 = bus.in_ir[14:12];
    assign w_rd     = bus.in_ir[11:7];

    always_comb begin
        w_legal    = 1'b1;
        w_wr_reg   = 1'b0;
        w_wr_csr   = 1'b0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_imm_type = IMM_NONE;
        case (w_opcode)
            c_opc_lui, c_opc_auipc: begin
                w_imm_type = IMM_U;
                w_wr_reg   = 1'b1;
            end
            c_opc_jal: begin
                w_imm_type = IMM_J;
                w_wr_reg   = 1'b1;
            end
            c_opc_jalr, c_opc_load: begin
                w_imm_type = IMM_I;
                w_wr_reg   = 1'b1;
                w_uses_rs1 = 1'b1;
            end
            c_opc_branch: begin
                w_imm_type = IMM_B;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            c_opc_store: begin
                w_imm_type = IMM_S;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            c_opc_op_imm: begin
                w_imm_type = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
                w_wr_reg   = 1'b1;
                w_uses_rs1 = 1'b1;
            end
            c_opc_op: begin
                w_wr_reg   = 1'b1;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            c_opc_csr: begin
                w_wr_reg   = 1'b1;
                w_uses_rs1 = (w_funct3 == 3'b001) || (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
                if (w_funct3 != 3'b000) begin
                    if (CSR_EN) begin
                        w_wr_csr   = 1'b1;
                        w_imm_type = IMM_CSR;
                    end else begin
                        w_legal = 1'b0;
                    end
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .ir       (bus.in_ir),
        .imm_type (w_imm_type),
        .imm      (w_imm)
    );

    // Only a held load can stall the incoming consumer; the load itself keeps draining.
    assign w_hazard = LOAD_USE_STALL && r_valid && r_is_load && (r_rd != 5'd0) &&
                      ((w_uses_rs1 && (bus.in_ir[19:15] == r_rd)) ||
                       (w_uses_rs2 && (bus.in_ir[24:20] == r_rd)));

    assign w_in_ready = !bus.flush && !w_hazard && (!r_valid || bus.ex_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7   <= '0;
            r_csr_addr <= '0;
            r_imm      <= '0;
            r_wr_reg_n <= 1'b1;
            r_wr_csr_n <= 1'b1;
            r_is_load  <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (bus.in_valid && w_in_ready) begin
            r_valid    <= 1'b1;
            r_pc       <= bus.in_pc;
            r_rd       <= w_rd;
            r_rs1      <= bus.in_ir[19:15];
            r_rs2      <= bus.in_ir[24:20];
            r_opcode   <= w_opcode;
            r_funct3   <= w_funct3;
            r_funct7   <= bus.in_ir[31:25];
            r_csr_addr <= bus.in_ir[31:20];
            r_imm      <= w_legal ? w_imm : '0;
            r_wr_reg_n <= !(w_wr_reg && w_legal && (w_rd != 5'd0));
            r_wr_csr_n <= !(w_wr_csr && w_legal);
            r_is_load  <= (w_opcode == c_opc_load);
            r_illegal  <= !w_legal;
        end else if (r_valid && bus.ex_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.rs1          = bus.in_ir[19:15];
    assign bus.rs2          = bus.in_ir[24:20];
    assign bus.hazard       = w_hazard;
    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid;
    assign bus.out_pc       = r_pc;
    assign bus.out_rd       = r_rd;
    assign bus.out_rs1      = r_rs1;
    assign bus.out_rs2      = r_rs2;
    assign bus.out_opcode   = r_opcode;
    assign bus.out_funct3   = r_funct3;
    assign bus.out_funct7   = r_funct7;
    assign bus.out_csr_addr = r_csr_addr;
    assign bus.out_imm      = r_imm;
    // A bubble must never write, whatever stale fields it still holds.
    assign bus.out_wr_reg_n = r_wr_reg_n | ~r_valid;
    assign bus.out_wr_csr_n = r_wr_csr_n | ~r_valid;
    assign bus.out_is_load  = r_is_load;
    assign bus.out_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_pipe_stage
// Brief    : Two configurations of id_pipe_stage against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_id_pipe_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_pipe_stage_if #(.XLEN(32)) bus0 ();
    id_pipe_stage_if #(.XLEN(64)) bus1 ();

    id_pipe_stage #(.XLEN(32), .CSR_EN(1'b1), .LOAD_USE_STALL(1'b1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    id_pipe_stage #(.XLEN(64), .CSR_EN(1'b0), .LOAD_USE_STALL(1'b0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] csr;
        logic [63:0] pc, imm;
        logic        wr_reg_n, wr_csr_n, is_load, illegal;
    } held_t;

    held_t m [2];
    bit    p_csr [2] = '{1'b1, 1'b0};
    bit    p_lus [2] = '{1'b1, 1'b0};
    bit    p_x64 [2] = '{1'b0, 1'b1};

    logic        cur_valid, cur_flush, cur_exr;
    logic [31:0] cur_ir;
    logic [63:0] cur_pc;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic held_t held_reset();
        held_t d;
        d.valid = 1'b0; d.rd = '0; d.rs1 = '0; d.rs2 = '0; d.opc = '0; d.f3 = '0;
        d.f7 = '0; d.csr = '0; d.pc = '0; d.imm = '0;
        d.wr_reg_n = 1'b1; d.wr_csr_n = 1'b1; d.is_load = 1'b0; d.illegal = 1'b0;
        return d;
    endfunction

    // What the EX stage should see for this instruction, from the ISA rules directly.
    function automatic held_t decode(input logic [31:0] ir, input logic [63:0] pc, input int k);
        held_t       d;
        logic [63:0] imm = '0;
        bit          legal = 1'b1;
        bit          wreg = 1'b1;
        bit          csr = 1'b0;
        case (ir[6:0])
            7'h37, 7'h17: imm = $signed({ir[31:12], 12'h000});
            7'h6F:        imm = $signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
            7'h67, 7'h03: imm = $signed(ir[31:20]);
            7'h63: begin imm = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}); wreg = 1'b0; end
            7'h23: begin imm = $signed({ir[31:25], ir[11:7]}); wreg = 1'b0; end
            7'h13: begin
                if (ir[13:12] == 2'b01) imm = {59'b0, ir[24:20]};
                else                    imm = $signed(ir[31:20]);
            end
            7'h33: imm = '0;
            7'h73: begin
                if (ir[14:12] != 3'b000) begin
                    if (p_csr[k]) begin csr = 1'b1; imm = {59'b0, ir[19:15]}; end
                    else legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin imm = '0; wreg = 1'b0; end
        if (!p_x64[k]) begin imm[63:32] = '0; pc[63:32] = '0; end
        d.valid = 1'b1; d.rd = ir[11:7]; d.rs1 = ir[19:15]; d.rs2 = ir[24:20];
        d.opc = ir[6:0]; d.f3 = ir[14:12]; d.f7 = ir[31:25]; d.csr = ir[31:20];
        d.pc = pc; d.imm = imm;
        d.wr_reg_n = !(wreg && (ir[11:7] != 5'd0));
        d.wr_csr_n = !csr;
        d.is_load  = (ir[6:0] == 7'h03);
        d.illegal  = !legal;
        return d;
    endfunction

    function automatic bit model_hazard(input int k);
        logic [6:0] op = cur_ir[6:0];
        bit u1, u2;
        u1 = (op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33}) ||
             (op == 7'h73 && (cur_ir[14:12] inside {3'd1, 3'd2, 3'd3}));
        u2 = op inside {7'h63, 7'h23, 7'h33};
        return p_lus[k] && m[k].valid && m[k].is_load && (m[k].rd != 5'd0) &&
               ((u1 && cur_ir[19:15] == m[k].rd) || (u2 && cur_ir[24:20] == m[k].rd));
    endfunction

    function automatic bit model_ready(input int k);
        return !cur_flush && !model_hazard(k) && (!m[k].valid || cur_exr);
    endfunction

    function automatic logic [43:0] exp_fields(input int k);
        return {m[k].rd, m[k].rs1, m[k].rs2, m[k].opc, m[k].f3, m[k].f7, m[k].csr};
    endfunction

    function automatic logic [3:0] exp_ctl(input int k);
        return {m[k].wr_reg_n | !m[k].valid, m[k].wr_csr_n | !m[k].valid, m[k].is_load, m[k].illegal};
    endfunction

    task automatic check_regs();
        chk("valid0", bus0.out_valid, m[0].valid);
        chk("fields0", {bus0.out_rd, bus0.out_rs1, bus0.out_rs2, bus0.out_opcode, bus0.out_funct3,
                        bus0.out_funct7, bus0.out_csr_addr}, exp_fields(0));
        chk("pc0", bus0.out_pc, m[0].pc);
        chk("imm0", bus0.out_imm, m[0].imm);
        chk("ctl0", {bus0.out_wr_reg_n, bus0.out_wr_csr_n, bus0.out_is_load, bus0.out_illegal}, exp_ctl(0));
        chk("valid1", bus1.out_valid, m[1].valid);
        chk("fields1", {bus1.out_rd, bus1.out_rs1, bus1.out_rs2, bus1.out_opcode, bus1.out_funct3,
                        bus1.out_funct7, bus1.out_csr_addr}, exp_fields(1));
        chk("pc1", bus1.out_pc, m[1].pc);
        chk("imm1", bus1.out_imm, m[1].imm);
        chk("ctl1", {bus1.out_wr_reg_n, bus1.out_wr_csr_n, bus1.out_is_load, bus1.out_illegal}, exp_ctl(1));
    endtask

    // Called one time unit after a rising edge; checks the combinational outputs.
    task automatic drive(input bit v, input logic [31:0] ir, input bit fl, input bit exr, input bit rn);
        cur_valid = v; cur_ir = ir; cur_flush = fl; cur_exr = exr;
        cur_pc = {$urandom, $urandom};
        bus0.in_valid = v; bus0.in_ir = ir; bus0.in_pc = cur_pc[31:0];
        bus0.flush = fl;   bus0.ex_ready = exr;
        bus1.in_valid = v; bus1.in_ir = ir; bus1.in_pc = cur_pc;
        bus1.flush = fl;   bus1.ex_ready = exr;
        rst_n = rn;
        #1;
        chk("rs0", {bus0.rs1, bus0.rs2}, {ir[19:15], ir[24:20]});
        chk("hazard0", bus0.hazard, model_hazard(0));
        chk("ready0", bus0.in_ready, model_ready(0));
        chk("rs1", {bus1.rs1, bus1.rs2}, {ir[19:15], ir[24:20]});
        chk("hazard1", bus1.hazard, model_hazard(1));
        chk("ready1", bus1.in_ready, model_ready(1));
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            bit rdy = model_ready(k);
            if (!rst_n)                  m[k] = held_reset();
            else if (cur_flush)          m[k].valid = 1'b0;
            else if (cur_valid && rdy)   m[k] = decode(cur_ir, cur_pc, k);
            else if (m[k].valid && cur_exr) m[k].valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir = $urandom;
        case ($urandom_range(0, 10))
            0:  ir[6:0] = 7'h37;
            1:  ir[6:0] = 7'h17;
            2:  ir[6:0] = 7'h6F;
            3:  ir[6:0] = 7'h67;
            4:  ir[6:0] = 7'h63;
            5:  ir[6:0] = 7'h03;
            6:  ir[6:0] = 7'h23;
            7:  ir[6:0] = 7'h13;
            8:  ir[6:0] = 7'h33;
            9:  ir[6:0] = 7'h73;
            default: ir[6:0] = 7'($urandom);
        endcase
        // Narrow register indices so load-use collisions come up often.
        ir[11:7]  = 5'($urandom_range(0, 3));
        ir[19:15] = 5'($urandom_range(0, 3));
        ir[24:20] = 5'($urandom_range(0, 3));
        return ir;
    endfunction

    localparam logic [31:0] c_addi  = 32'h00510093;
    localparam logic [31:0] c_lw    = 32'h0000A183;
    localparam logic [31:0] c_add   = 32'h00118233;
    localparam logic [31:0] c_beq   = 32'hFE000EE3;
    localparam logic [31:0] c_csrrw = 32'h300312F3;

    initial begin
        m[0] = held_reset();
        m[1] = held_reset();
        cur_valid = 1'b0; cur_ir = '0; cur_flush = 1'b0; cur_exr = 1'b0; cur_pc = '0;
        bus0.in_valid = 1'b0; bus0.in_ir = '0; bus0.in_pc = '0; bus0.flush = 1'b0; bus0.ex_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_ir = '0; bus1.in_pc = '0; bus1.flush = 1'b0; bus1.ex_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus0.out_valid, 1'b0);
        chk("rst_wr_n", {bus0.out_wr_reg_n, bus0.out_wr_csr_n}, 2'b11);
        check_regs();

        drive(1'b1, c_addi, 1'b0, 1'b1, 1'b1); tick();
        chk("addi_valid", bus0.out_valid, 1'b1);
        chk("addi_rd", bus0.out_rd, 5'd1);
        chk("addi_rs1", bus0.out_rs1, 5'd2);
        chk("addi_imm", bus0.out_imm, 64'd5);
        chk("addi_wr_reg_n", bus0.out_wr_reg_n, 1'b0);

        drive(1'b1, c_lw, 1'b0, 1'b1, 1'b1); tick();
        drive(1'b1, c_add, 1'b0, 1'b1, 1'b1);
        chk("lu_hazard", bus0.hazard, 1'b1);
        chk("lu_in_ready", bus0.in_ready, 1'b0);
        chk("lu_nostall_hazard", bus1.hazard, 1'b0);
        tick();
        chk("lu_bubble", bus0.out_valid, 1'b0);
        chk("lu_nostall_rd", bus1.out_rd, 5'd4);
        drive(1'b1, c_add, 1'b0, 1'b1, 1'b1);
        chk("lu_accept", bus0.in_ready, 1'b1);
        tick();
        chk("lu_add_valid", bus0.out_valid, 1'b1);
        chk("lu_add_rd", bus0.out_rd, 5'd4);

        drive(1'b1, c_beq, 1'b0, 1'b1, 1'b1); tick();
        chk("beq_imm32", bus0.out_imm, 64'h0000_0000_FFFF_FFFC);
        chk("beq_imm64", bus1.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_wr_reg_n", bus0.out_wr_reg_n, 1'b1);

        drive(1'b1, c_csrrw, 1'b0, 1'b1, 1'b1); tick();
        chk("csr_addr", bus0.out_csr_addr, 12'h300);
        chk("csr_wr_n", {bus0.out_wr_reg_n, bus0.out_wr_csr_n}, 2'b00);
        chk("csr_off_illegal", bus1.out_illegal, 1'b1);
        chk("csr_off_wr_n", {bus1.out_wr_reg_n, bus1.out_wr_csr_n}, 2'b11);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, c_addi, (i == 2), 1'b0, 1'b1);
            chk("stall_in_ready", bus0.in_ready, 1'b0);
            tick();
            chk("stall_rd", bus0.out_rd, 5'd5);
        end
        chk("flush_valid", bus0.out_valid, 1'b0);

        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1); tick();
        chk("ill_flag", bus0.out_illegal, 1'b1);
        chk("ill_imm", bus0.out_imm, 64'd0);
        chk("ill_wr_n", {bus0.out_wr_reg_n, bus0.out_wr_csr_n}, 2'b11);
        drive(1'b1, c_addi, 1'b0, 1'b0, 1'b0); tick();
        chk("rst2_valid", bus0.out_valid, 1'b0);
        chk("rst2_illegal", bus0.out_illegal, 1'b0);
        chk("rst2_wr_n", {bus0.out_wr_reg_n, bus0.out_wr_csr_n}, 2'b11);

        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 9) < 8), rand_ir(), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) != 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_pipe_stage.md
# id_pipe_stage

Registered, parametrised instruction-decode stage for the RV32I pipeline, sitting between the IF/ID register and the EX stage. It splits the instruction word, extracts and sign-extends the immediate to XLEN, and generates register-file and CSR write enables plus an illegal-opcode flag. It holds the result in an ID/EX pipeline register with a valid/ready handshake. It also detects load-use hazards against the instruction it holds, and handles flush requests from branch resolution.

## Interface
- XLEN, 32: datapath width of pc and imm; legal values are 32 and 64.
- CSR_EN, 1: when 0, CSR opcode with funct3≠000 is illegal.
- LOAD_USE_STALL, 1: when 0, the hazard check is disabled and always 0.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  IF has an instruction.
- in_ir  in  32  instruction word.
- in_pc  in  XLEN  pc of in_ir.
- in_ready  out  1  stage accepts in_ir this cycle.
- flush  in  1  kill held and incoming instruction.
- ex_ready  in  1  EX consumes the held instruction this cycle.
- rs1, rs2  out  5  combinational from in_ir, to the register file.
- hazard  out  1  combinational load-use stall indication.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_pc  out  XLEN  held pc.
- out_rd  out  5  held rd.
- out_rs1, out_rs2  out  5  held source register indices.
- out_opcode  out  7  held opcode.
- out_funct3  out  3  held funct3.
- out_funct7  out  7  held funct7.
- out_csr_addr  out  12  held ir[31:20].
- out_imm  out  XLEN  held extended immediate.
- out_wr_reg_n  out  1  register write, 0 = write.
- out_wr_csr_n  out  1  CSR write, 0 = write.
- out_is_load  out  1  held instruction is a load.
- out_illegal  out  1  held instruction has an unknown opcode.

## Operation
- Immediate types and extension:
  - I: ir[31:20], sign-extended.
  - S: {ir[31:25], ir[11:7]}, sign-extended.
  - B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}, sign-extended.
  - U: {ir[31:12], 12'b0}, sign-extended.
  - J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}, sign-extended.
  - shamt (OP-IMM, funct3 001/101): ir[24:20], zero-extended.
  - CSR: ir[19:15], zero-extended.
  - Any other opcode: imm = 0.
- out_wr_reg_n = 0 only when rd≠0, instruction is legal, and opcode ∈ {LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM}.
- out_wr_csr_n = 0 only when opcode = SYSTEM, funct3≠000 and CSR_EN = 1.
- Illegal instruction:
  - Any opcode outside the ten RV32I opcodes is illegal.
  - Illegal forces both write enables to 1 and imm to 0.
- Source usage:
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP, and SYSTEM with funct3 ∈ {001, 010, 011}.
  - uses_rs2: BRANCH, STORE, OP.
- hazard = LOAD_USE_STALL & out_valid & out_is_load & out_rd≠0 & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
- in_ready = !flush & !hazard & (!out_valid | ex_ready).
- Register update, in priority order:
  1. rst_n = 0 → reset values.
  2. flush → out_valid ← 0.
  3. in_valid & in_ready → load all fields, out_valid ← 1.
  4. out_valid & ex_ready → out_valid ← 0. This covers hazard: a bubble is inserted and the load drains.
  5. Otherwise hold all fields.
- Reset values: all out_* fields = 0, except out_wr_reg_n = 1 and out_wr_csr_n = 1.
- When out_valid = 0, out_wr_reg_n and out_wr_csr_n read 1.

## Timing
- Latency is 1 cycle from acceptance to out_valid.
- Throughput is 1 instruction per cycle with no hazard.
- rs1, rs2, hazard and in_ready are combinational, with no state dependency beyond the ID/EX register.
- A load-use costs exactly one bubble. The dependent instruction is accepted the cycle after the load leaves.
- Stall (ex_ready = 0, out_valid = 1): every out_* field holds stable and in_ready = 0.
- flush together with in_valid: the instruction is dropped and out_valid = 0 next cycle.
- Reset mid-stall: out_valid = 0 next cycle, regardless of ex_ready.

## Structure
- Shared package rv32i_pkg holds the opcode localparams (lui … csr), the imm-type encoding (i, b, s, u, j, shamt, csr, none) and NOP_IR = 32'h00000013.
- One sub-module, imm_gen: combinational, parametrised by XLEN, with inputs ir and imm_type and output imm.
- Decode and control functions and the ID/EX register live in id_pipe_stage.

## Test plan
- Reset, then in_ir = 0x00510093 (addi x1,x2,5) with ex_ready = 1 → next cycle out_valid = 1, rd = 1, rs1 = 2, out_imm = 5, out_wr_reg_n = 0.
- 0x0000A183 (lw x3,0(x1)) then 0x00118233 (add x4,x3,x1):
  - hazard = 1 and in_ready = 0 for one cycle.
  - A bubble follows the load.
  - add appears two cycles after lw.
  - With LOAD_USE_STALL = 0 there is no bubble.
- 0xFE000EE3 (beq x0,x0,-4) → out_imm = 0xFFFFFFFC (XLEN = 64: 0xFFFFFFFFFFFFFFFC), out_wr_reg_n = 1.
- 0x300312F3 (csrrw x5,0x300,x6) → out_csr_addr = 0x300, out_wr_csr_n = 0, out_wr_reg_n = 0. With CSR_EN = 0: out_illegal = 1 and both write enables = 1.
- Hold ex_ready = 0 for 3 cycles with in_valid = 1 → outputs unchanged and in_ready = 0. Assert flush in the 3rd cycle → out_valid = 0 next cycle.
- Opcode 0x7F → out_illegal = 1, out_imm = 0, write enables = 1. Assert rst_n = 0 mid-stream → all outputs at reset values next cycle.
